// File: rtl/clock_divider_bank.sv
// clock_divider_bank: CHANNELS independent programmable clock dividers
// driven from one master clock, with per-channel enable and a tick strobe.
//
// Ports:
//   Master_Clock_In  master clock, all state on its rising edge
//   Reset            asynchronous active-high reset
//   Enable           per-channel run enable
//   Sync             restart every running channel at phase 0
//   Load_Valid       divisor write strobe
//   Load_Channel     channel targeted by the write (>= CHANNELS ignored)
//   Load_Divisor     new divisor, applied at the next period boundary
//   Clock_Out        registered divided clocks
//   Tick_Out         registered one-cycle strobe at each period start
//   Running_Out      channel currently counting
module clock_divider_bank #(
   parameter int CHANNELS    = 4,
   parameter int DIV_WIDTH   = 8,
   parameter int DIV_DEFAULT = 4,
   parameter int CH_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 Master_Clock_In,
   input  logic                 Reset,
   input  logic [CHANNELS-1:0]  Enable,
   input  logic                 Sync,
   input  logic                 Load_Valid,
   input  logic [CH_WIDTH-1:0]  Load_Channel,
   input  logic [DIV_WIDTH-1:0] Load_Divisor,
   output logic [CHANNELS-1:0]  Clock_Out,
   output logic [CHANNELS-1:0]  Tick_Out,
   output logic [CHANNELS-1:0]  Running_Out
);

   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_DEFAULT);
   localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
   localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] cnt_q  [CHANNELS];
   logic [DIV_WIDTH-1:0] cnt_d  [CHANNELS];
   logic [DIV_WIDTH-1:0] act_q  [CHANNELS];
   logic [DIV_WIDTH-1:0] act_d  [CHANNELS];
   logic [DIV_WIDTH-1:0] pend_q [CHANNELS];
   logic [DIV_WIDTH-1:0] pend_d [CHANNELS];

   logic [CHANNELS-1:0] run_q;
   logic [CHANNELS-1:0] run_d;
   logic [CHANNELS-1:0] clk_q;
   logic [CHANNELS-1:0] clk_d;
   logic [CHANNELS-1:0] tick_q;
   logic [CHANNELS-1:0] tick_d;

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         // Out-of-range channel numbers never match any i, so they drop.
         if (Load_Valid && (Load_Channel == CH_WIDTH'(i)))
            pend_d[i] = Load_Divisor;
         else
            pend_d[i] = pend_q[i];

         cnt_d[i] = '0;
         act_d[i] = act_q[i];
         run_d[i] = 1'b0;

         if (!Enable[i]) begin
            act_d[i] = pend_d[i];
         end else if (!run_q[i]) begin
            // Idle channels take a same-cycle load directly, so a write
            // to an idle channel takes effect on the write edge itself.
            act_d[i] = pend_d[i];
            run_d[i] = (pend_d[i] >= DIV_MIN);
         end else if (Sync || (cnt_q[i] == act_q[i] - ONE)) begin
            // Period boundary: the pending value from before this edge
            // becomes active; a too-small divisor parks the channel.
            act_d[i] = pend_q[i];
            run_d[i] = (pend_q[i] >= DIV_MIN);
         end else begin
            cnt_d[i] = cnt_q[i] + ONE;
            run_d[i] = 1'b1;
         end

         clk_d[i]  = run_d[i] && (cnt_d[i] < (act_d[i] >> 1));
         tick_d[i] = run_d[i] && (cnt_d[i] == '0);
      end
   end

   always_ff @(posedge Master_Clock_In or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= '0;
            act_q[i]  <= DIV_RST;
            pend_q[i] <= DIV_RST;
         end
         run_q  <= '0;
         clk_q  <= '0;
         tick_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_q[i]  <= cnt_d[i];
            act_q[i]  <= act_d[i];
            pend_q[i] <= pend_d[i];
         end
         run_q  <= run_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign Clock_Out   = clk_q;
   assign Tick_Out    = tick_q;
   assign Running_Out = run_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: directed test of clock_divider_bank with
// hand-computed expected waveforms for each channel scenario.
module tb_clock_divider_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] en;
   logic       sync;
   logic       lv;
   logic [2:0] lc;
   logic [7:0] ld;
   logic [3:0] co;
   logic [3:0] to;
   logic [3:0] ro;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clock_divider_bank #(
      .CHANNELS    (4),
      .DIV_WIDTH   (8),
      .DIV_DEFAULT (4),
      .CH_WIDTH    (3)
   ) dut (
      .Master_Clock_In (clk),
      .Reset           (rst),
      .Enable          (en),
      .Sync            (sync),
      .Load_Valid      (lv),
      .Load_Channel    (lc),
      .Load_Divisor    (ld),
      .Clock_Out       (co),
      .Tick_Out        (to),
      .Running_Out     (ro)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic load(input logic [2:0] ch, input logic [7:0] d);
      lv = 1'b1;
      lc = ch;
      ld = d;
      step();
      lv = 1'b0;
   endtask

   initial begin
      rst  = 1'b1;
      en   = '0;
      sync = 1'b0;
      lv   = 1'b0;
      lc   = '0;
      ld   = '0;
      #1;
      check("rst_clk", co, 0);
      check("rst_tick", to, 0);
      check("rst_run", ro, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // ch0 default divisor 4: 1,1,0,0
      en = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("s1_clk%0d", k), co,
               (k % 4 < 2) ? 4'b0001 : 4'b0000);
         check($sformatf("s1_tick%0d", k), to,
               (k % 4 == 0) ? 4'b0001 : 4'b0000);
         check($sformatf("s1_run%0d", k), ro, 4'b0001);
      end

      // ch1 divisor 5, then 2 loaded mid-period
      en = '0;
      step();
      load(3'd1, 8'd5);
      en = 4'b0010;
      for (int k = 0; k < 13; k++) begin
         step();
         check($sformatf("s2a_clk%0d", k), co[1], (k % 5 < 2));
         check($sformatf("s2a_tick%0d", k), to[1], (k % 5 == 0));
      end
      lv = 1'b1;
      lc = 3'd1;
      ld = 8'd2;
      for (int m = 0; m < 8; m++) begin
         step();
         lv = 1'b0;
         check($sformatf("s2b_clk%0d", m), co[1],
               (m >= 2 && m % 2 == 0));
         check($sformatf("s2b_tick%0d", m), to[1],
               (m >= 2 && m % 2 == 0));
      end

      // ch2 divisor 6, load 3 on the wrap edge
      en = '0;
      step();
      load(3'd2, 8'd6);
      en = 4'b0100;
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("s3a_clk%0d", k), co[2], (k < 3));
         check($sformatf("s3a_tick%0d", k), to[2], (k == 0));
      end
      lv = 1'b1;
      lc = 3'd2;
      ld = 8'd3;
      step();
      lv = 1'b0;
      check("s3_wrap_clk", co[2], 1);
      check("s3_wrap_tick", to[2], 1);
      for (int k = 1; k < 6; k++) begin
         step();
         check($sformatf("s3b_clk%0d", k), co[2], (k < 3));
         check($sformatf("s3b_tick%0d", k), to[2], 0);
      end
      for (int k = 0; k < 6; k++) begin
         step();
         check($sformatf("s3c_clk%0d", k), co[2], (k % 3 == 0));
         check($sformatf("s3c_tick%0d", k), to[2], (k % 3 == 0));
      end

      // ch0 /4 and ch1 /6 out of phase, then Sync
      en = '0;
      step();
      load(3'd1, 8'd6);
      en = 4'b0001;
      step();
      step();
      en = 4'b0011;
      for (int k = 0; k < 3; k++) step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("s4_sync_tick", to, 4'b0011);
      check("s4_sync_clk", co, 4'b0011);
      for (int k = 1; k <= 12; k++) begin
         step();
         check($sformatf("s4_tick%0d", k), to[1:0],
               {(k % 6 == 0), (k % 4 == 0)});
         check($sformatf("s4_clk%0d", k), co[1:0],
               {(k % 6 < 3), (k % 4 < 2)});
      end

      // ch3 /4, load 1 -> parks after the period, load 8 -> restarts
      en = 4'b1000;
      step();
      check("s5_start_run", ro, 4'b1000);
      check("s5_start_tick", to, 4'b1000);
      step();
      lv = 1'b1;
      lc = 3'd3;
      ld = 8'd1;
      step();
      lv = 1'b0;
      check("s5_c2_run", ro, 4'b1000);
      check("s5_c2_clk", co, 4'b0000);
      step();
      check("s5_c3_run", ro, 4'b1000);
      step();
      check("s5_idle_run", ro, 4'b0000);
      check("s5_idle_clk", co, 4'b0000);
      check("s5_idle_tick", to, 4'b0000);
      step();
      check("s5_idle2_run", ro, 4'b0000);
      load(3'd3, 8'd8);
      check("s5_re_run", ro, 4'b1000);
      check("s5_re_tick", to, 4'b1000);
      check("s5_re_clk", co, 4'b1000);
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("s5_clk%0d", k), co[3], (k % 8 < 4));
         check($sformatf("s5_tick%0d", k), to[3], (k % 8 == 0));
      end

      // async reset mid-period, out-of-range write ignored
      en = 4'b1111;
      step();
      step();
      step();
      load(3'd7, 8'd3);
      #2 rst = 1'b1;
      #1;
      check("s6_rst_clk", co, 0);
      check("s6_rst_tick", to, 0);
      check("s6_rst_run", ro, 0);
      @(negedge clk);
      check("s6_rsthold_run", ro, 0);
      en  = '0;
      rst = 1'b0;
      load(3'd7, 8'd3);
      en = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("s6_clk%0d", k), co,
               (k % 4 < 2) ? 4'hF : 4'h0);
         check($sformatf("s6_tick%0d", k), to,
               (k % 4 == 0) ? 4'hF : 4'h0);
         check($sformatf("s6_run%0d", k), ro, 4'hF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
